// File: rtl/lsu_pkg.sv
// Shared types, address map constants and lane helpers for the RV32I load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    RG_NONE,
    RG_RAM,
    RG_LEDR,
    RG_LEDG,
    RG_HEX,
    RG_LCD,
    RG_SW
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  // MMIO occupies 4 KiB pages; only the page number selects a register.
  localparam logic [31:0] PAGE_MASK   = 32'hFFFF_F000;
  localparam logic [31:0] LEDR_BASE   = 32'h1000_0000;
  localparam logic [31:0] LEDG_BASE   = 32'h1000_1000;
  localparam logic [31:0] HEX_BASE    = 32'h1000_2000;
  localparam logic [31:0] HEX_STRIDE  = 32'h0000_1000;
  localparam logic [31:0] LCD_BASE    = 32'h1000_6000;
  localparam logic [31:0] SW_BASE     = 32'h1001_0000;
  localparam int          HEX_MAX_GRP = 4;

  // Byte-lane enables for an access of the given size at byte offset lo.
  function automatic logic [3:0] bmask(input size_e size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Right-justified store data copied onto every lane it could land in.
  function automatic logic [31:0] replicate(input size_e size, input logic [31:0] d);
    case (size)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Byte-enable merge of new data into an existing 32-bit register.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Shift the addressed lane down to bit 0 and sign/zero extend it.
  function automatic logic [31:0] extend(input logic [31:0] word, input size_e size,
                                         input logic [1:0] lo, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: return uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: return uns ? {16'h0, h} : {{16{h[15]}}, h};
      SZ_WORD: return word;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ram.sv
// Data RAM: 2**AW x 32, byte-enable write, registered read-first output.
module lsu_ram
  import lsu_pkg::*;
#(
  parameter int AW = 11
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] mem [2**AW];

  // Byte-lane write and synchronous read of the addressed word.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so ordering of statements cannot create races.
  // NOTE: the array has no reset so it maps onto block RAM; software must write before it reads.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      for (int b = 0; b < 4; b++)
        if (i_we[b]) mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      o_rdata <= mem[i_addr];
    end
  end

endmodule

// File: rtl/lsu_mmio_hs.sv
// Handshaked load/store unit: request decode, FSM, MMIO registers, lane logic.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses return err
// instead of being force-aligned).
module lsu_mmio_hs
  import lsu_pkg::*;
#(
  parameter int RAM_AW  = 11,
  parameter int NUM_HEX = 8,
  parameter int LEDR_W  = 17,
  parameter int LEDG_W  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [31:0]          i_req_addr,
  input  logic                 i_req_wren,
  input  logic [1:0]           i_req_size,
  input  logic                 i_req_unsigned,
  input  logic [31:0]          i_req_wdata,
  output logic                 o_rsp_valid,
  output logic [31:0]          o_rsp_rdata,
  output logic                 o_rsp_err,
  output logic [LEDR_W-1:0]    o_io_ledr,
  output logic [LEDG_W-1:0]    o_io_ledg,
  output logic [7*NUM_HEX-1:0] o_io_hex,
  output logic [31:0]          o_io_lcd,
  input  logic [31:0]          i_io_sw
);

  localparam int NUM_GRP = NUM_HEX / 4;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_e      state;
  logic        ready_q;
  logic        accept;
  size_e       req_size;

  region_e     rg_in;
  logic [1:0]  grp_in;
  logic [31:0] hex_off;
  logic [1:0]  lo_in;
  logic        mis_in;
  logic        err_in;
  logic        wr_ok;
  logic [3:0]  be_in;
  logic [31:0] wdata_rep;

  size_e       size_q;
  logic [1:0]  lo_q;
  logic        uns_q;
  logic        wren_q;
  logic        err_q;
  region_e     rg_q;
  logic [1:0]  grp_q;

  logic [31:0] ram_rdata;
  logic [31:0] mmio_rd;
  logic [31:0] raw_rd;

  logic [LEDR_W-1:0] ledr_q;
  logic [LEDG_W-1:0] ledg_q;
  logic [6:0]        hex_q [NUM_HEX];
  logic [31:0]       lcd_q;
  logic [31:0]       sw_meta;
  logic [31:0]       sw_sync;

  assign o_req_ready = ready_q;
  assign accept      = i_req_valid && ready_q;
  assign req_size    = size_e'(i_req_size);
  assign hex_off     = i_req_addr - HEX_BASE;

  // Decode the incoming request: region, lane offset, alignment and error.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rg_in  = RG_NONE;
    grp_in = 2'b00;
    if ((i_req_addr >> (RAM_AW + 2)) == 32'h0)            rg_in = RG_RAM;
    else if ((i_req_addr & PAGE_MASK) == LEDR_BASE)       rg_in = RG_LEDR;
    else if ((i_req_addr & PAGE_MASK) == LEDG_BASE)       rg_in = RG_LEDG;
    else if (i_req_addr >= HEX_BASE &&
             hex_off < 32'(NUM_GRP) * HEX_STRIDE) begin
      rg_in  = RG_HEX;
      grp_in = hex_off[13:12];
    end
    else if ((i_req_addr & PAGE_MASK) == LCD_BASE)        rg_in = RG_LCD;
    else if ((i_req_addr & PAGE_MASK) == SW_BASE)         rg_in = RG_SW;

    case (req_size)
      SZ_HALF: begin mis_in = i_req_addr[0];    lo_in = {i_req_addr[1], 1'b0}; end
      SZ_WORD: begin mis_in = |i_req_addr[1:0]; lo_in = 2'b00;                 end
      default: begin mis_in = 1'b0;             lo_in = i_req_addr[1:0];       end
    endcase

    err_in    = (req_size == SZ_ILL) || (TRAP_EN && mis_in);
    wr_ok     = accept && i_req_wren && !err_in;
    be_in     = bmask(req_size, lo_in);
    wdata_rep = replicate(req_size, i_req_wdata);
  end

  lsu_ram #(.AW(RAM_AW)) u_ram (
    .i_clk   (i_clk),
    .i_en    (accept),
    .i_we    ((wr_ok && rg_in == RG_RAM) ? be_in : 4'b0000),
    .i_addr  (i_req_addr[RAM_AW+1:2]),
    .i_wdata (wdata_rep),
    .o_rdata (ram_rdata)
  );

  // Read value of the MMIO register selected by the captured request.
  always_comb begin
    mmio_rd = 32'h0;
    case (rg_q)
      RG_LEDR: mmio_rd = 32'(ledr_q);
      RG_LEDG: mmio_rd = 32'(ledg_q);
      RG_LCD:  mmio_rd = lcd_q;
      RG_SW:   mmio_rd = sw_sync;
      RG_HEX: begin
        for (int g = 0; g < NUM_GRP; g++)
          if (grp_q == 2'(g))
            mmio_rd = {1'b0, hex_q[4*g+3], 1'b0, hex_q[4*g+2],
                       1'b0, hex_q[4*g+1], 1'b0, hex_q[4*g]};
      end
      default: mmio_rd = 32'h0;
    endcase
    raw_rd = (rg_q == RG_RAM) ? ram_rdata : mmio_rd;
  end

  // Request FSM: capture on accept, form the response in ACCESS, pulse it in RESP.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      ready_q     <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= 32'h0;
      o_rsp_err   <= 1'b0;
      size_q      <= SZ_BYTE;
      lo_q        <= 2'b00;
      uns_q       <= 1'b0;
      wren_q      <= 1'b0;
      err_q       <= 1'b0;
      rg_q        <= RG_NONE;
      grp_q       <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          o_rsp_valid <= 1'b0;
          if (accept) begin
            state   <= ST_ACCESS;
            ready_q <= 1'b0;
            size_q  <= req_size;
            lo_q    <= lo_in;
            uns_q   <= i_req_unsigned;
            wren_q  <= i_req_wren;
            err_q   <= err_in;
            rg_q    <= rg_in;
            grp_q   <= grp_in;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_ACCESS: begin
          state       <= ST_RESP;
          o_rsp_valid <= 1'b1;
          o_rsp_err   <= err_q;
          o_rsp_rdata <= (wren_q || err_q) ? 32'h0 : extend(raw_rd, size_q, lo_q, uns_q);
        end
        ST_RESP: begin
          state       <= ST_IDLE;
          o_rsp_valid <= 1'b0;
          ready_q     <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // MMIO register writes, committed on the accept edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ledr_q <= '0;
      ledg_q <= '0;
      lcd_q  <= 32'h0;
      for (int k = 0; k < NUM_HEX; k++) hex_q[k] <= 7'h0;
    end else if (wr_ok) begin
      case (rg_in)
        RG_LEDR: ledr_q <= LEDR_W'(merge(32'(ledr_q), wdata_rep, be_in));
        RG_LEDG: ledg_q <= LEDG_W'(merge(32'(ledg_q), wdata_rep, be_in));
        RG_LCD:  lcd_q  <= merge(lcd_q, wdata_rep, be_in);
        RG_HEX: begin
          for (int g = 0; g < NUM_GRP; g++)
            if (grp_in == 2'(g))
              for (int b = 0; b < 4; b++)
                if (be_in[b]) hex_q[4*g+b] <= wdata_rep[8*b +: 7];
        end
        default: ;
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sw_meta <= 32'h0;
      sw_sync <= 32'h0;
    end else begin
      sw_meta <= i_io_sw;
      sw_sync <= sw_meta;
    end
  end

  // Flatten the digit registers onto the seven-segment bus.
  always_comb begin
    o_io_hex = '0;
    for (int k = 0; k < NUM_HEX; k++) o_io_hex[7*k +: 7] = hex_q[k];
  end

  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_lcd  = lcd_q;

endmodule

// File: tb/tb_lsu_mmio_hs.sv
// Self-checking bench for lsu_mmio_hs: directed cases plus randomized traffic against
// a byte-addressed reference model of RAM and MMIO.
module tb_lsu_mmio_hs;

  logic        i_clk;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic        i_req_wren;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [16:0] o_io_ledr;
  logic [7:0]  o_io_ledg;
  logic [55:0] o_io_hex;
  logic [31:0] o_io_lcd;
  logic [31:0] i_io_sw;

  lsu_mmio_hs dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_addr     (i_req_addr),
    .i_req_wren     (i_req_wren),
    .i_req_size     (i_req_size),
    .i_req_unsigned (i_req_unsigned),
    .i_req_wdata    (i_req_wdata),
    .o_rsp_valid    (o_rsp_valid),
    .o_rsp_rdata    (o_rsp_rdata),
    .o_rsp_err      (o_rsp_err),
    .o_io_ledr      (o_io_ledr),
    .o_io_ledg      (o_io_ledg),
    .o_io_hex       (o_io_hex),
    .o_io_lcd       (o_io_lcd),
    .i_io_sw        (i_io_sw)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int R_NONE = 0, R_RAM = 1, R_LEDR = 2, R_LEDG = 3, R_HEX = 4, R_LCD = 5, R_SW = 6;

  logic [7:0]  ram_m [8192];
  logic [31:0] ledr_m, ledg_m, lcd_m, sw_m;
  logic [6:0]  hex_m [8];

  function automatic int region_of(input logic [31:0] a);
    if (a < 32'h0000_2000) return R_RAM;
    case (a[31:12])
      20'h10000:          return R_LEDR;
      20'h10001:          return R_LEDG;
      20'h10002, 20'h10003: return R_HEX;
      20'h10006:          return R_LCD;
      20'h10010:          return R_SW;
      default:            return R_NONE;
    endcase
  endfunction

  function automatic int digit_of(input logic [31:0] a);
    return 4 * (int'(a[31:12]) - 'h10002) + int'(a[1:0]);
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] a);
    int lane;
    lane = int'(a[1:0]);
    case (region_of(a))
      R_RAM:  return ram_m[a[12:0]];
      R_LEDR: return ledr_m[8*lane +: 8];
      R_LEDG: return ledg_m[8*lane +: 8];
      R_LCD:  return lcd_m[8*lane +: 8];
      R_SW:   return sw_m[8*lane +: 8];
      R_HEX:  return {1'b0, hex_m[digit_of(a)]};
      default: return 8'h00;
    endcase
  endfunction

  task automatic set_byte(input logic [31:0] a, input logic [7:0] b);
    int lane;
    lane = int'(a[1:0]);
    case (region_of(a))
      R_RAM:  ram_m[a[12:0]] = b;
      R_LEDR: begin ledr_m[8*lane +: 8] = b; ledr_m &= 32'h0001_FFFF; end
      R_LEDG: begin ledg_m[8*lane +: 8] = b; ledg_m &= 32'h0000_00FF; end
      R_LCD:  lcd_m[8*lane +: 8] = b;
      R_HEX:  hex_m[digit_of(a)] = b[6:0];
      default: ;
    endcase
  endtask

  task automatic model_reset();
    ledr_m = 0; ledg_m = 0; lcd_m = 0;
    for (int k = 0; k < 8; k++) hex_m[k] = 7'h0;
  endtask

  task automatic model_req(input logic [31:0] addr, input logic wren, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata,
                           output logic [31:0] er, output logic ee);
    int nb;
    logic [31:0] ea, v;
    er = 32'h0;
    ee = 1'b0;
    if (size == 2'b11) begin ee = 1'b1; return; end
    nb = 1 << size;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((addr % nb) != 0) begin ee = 1'b1; return; end
`endif
    ea = addr - (addr % nb);
    if (wren) begin
      for (int i = 0; i < nb; i++) set_byte(ea + i, wdata[8*i +: 8]);
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = get_byte(ea + i);
      if (!uns && nb == 1) v = {{24{v[7]}}, v[7:0]};
      if (!uns && nb == 2) v = {{16{v[15]}}, v[15:0]};
      er = v;
    end
  endtask

  function automatic logic [55:0] exp_hex();
    logic [55:0] v;
    for (int k = 0; k < 8; k++) v[7*k +: 7] = hex_m[k];
    return v;
  endfunction

  task automatic check_io(input string tag);
    check({tag, "_ledr"}, o_io_ledr, ledr_m);
    check({tag, "_ledg"}, o_io_ledg, ledg_m);
    check({tag, "_hex"},  o_io_hex,  exp_hex());
    check({tag, "_lcd"},  o_io_lcd,  lcd_m);
  endtask

  // One full transaction; starts and ends just after a falling edge.
  task automatic do_req(input logic [31:0] addr, input logic wren, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        output logic [31:0] got_rd, output logic got_err);
    logic [31:0] er;
    logic        ee;
    int          w, lat;
    model_req(addr, wren, size, uns, wdata, er, ee);
    i_req_valid    = 1'b1;
    i_req_addr     = addr;
    i_req_wren     = wren;
    i_req_size     = size;
    i_req_unsigned = uns;
    i_req_wdata    = wdata;
    w = 0;
    while (!o_req_ready && w < 8) begin @(negedge i_clk); w++; end
    check("ready", o_req_ready, 1'b1);
    @(posedge i_clk);
    #1;
    // Scramble the request bus: the LSU must not re-sample it.
    i_req_valid    = 1'b0;
    i_req_addr     = $urandom;
    i_req_wren     = 1'($urandom);
    i_req_size     = 2'($urandom);
    i_req_unsigned = 1'($urandom);
    i_req_wdata    = $urandom;
    lat = 0;
    do begin @(negedge i_clk); lat++; end while (!o_rsp_valid && lat < 6);
    got_rd  = o_rsp_rdata;
    got_err = o_rsp_err;
    check("rsp_latency", lat, 2);
    check("rsp_rdata", o_rsp_rdata, er);
    check("rsp_err", o_rsp_err, ee);
    @(negedge i_clk);
    check("rsp_pulse_end", o_rsp_valid, 1'b0);
    check_io("io");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a;
    logic        er;
    int          pulses;

    i_reset = 1'b1; i_req_valid = 1'b0; i_req_addr = 0; i_req_wren = 0;
    i_req_size = 0; i_req_unsigned = 0; i_req_wdata = 0; i_io_sw = 0;
    sw_m = 0;
    model_reset();
    for (int i = 0; i < 8192; i++) ram_m[i] = 8'h00;

    repeat (3) @(negedge i_clk);
    check("reset_ready", o_req_ready, 1'b0);
    check("reset_rsp_valid", o_rsp_valid, 1'b0);
    check("reset_rdata", o_rsp_rdata, 32'h0);
    check("reset_err", o_rsp_err, 1'b0);
    check_io("reset");
    i_reset = 1'b0;
    @(negedge i_clk);
    check("ready_after_reset", o_req_ready, 1'b1);

    // Word store/load round trip.
    do_req(32'h0, 1, 2'b10, 0, 32'h1234_5678, rd, er);
    do_req(32'h0, 0, 2'b10, 0, 32'h0, rd, er);
    check("t1_lw", rd, 32'h1234_5678);

    // Byte store, signed/unsigned byte and half loads.
    do_req(32'h3, 1, 2'b00, 0, 32'h0000_0080, rd, er);
    do_req(32'h3, 0, 2'b00, 0, 32'h0, rd, er);
    check("t2_lb", rd, 32'hFFFF_FF80);
    do_req(32'h3, 0, 2'b00, 1, 32'h0, rd, er);
    check("t2_lbu", rd, 32'h0000_0080);
    do_req(32'h2, 0, 2'b01, 0, 32'h0, rd, er);
    check("t2_lh", rd, 32'hFFFF_8034);

    // Seven-segment group 0.
    do_req(32'h1000_2000, 1, 2'b10, 0, 32'h0A0B_0C0D, rd, er);
    check("t3_digit0", o_io_hex[6:0], 7'h0D);
    do_req(32'h1000_2000, 0, 2'b10, 0, 32'h0, rd, er);
    check("t3_lw_hex", rd, 32'h0A0B_0C0D);
    do_req(32'h1000_2002, 1, 2'b00, 0, 32'h0000_007F, rd, er);
    check("t3_digit2", o_io_hex[20:14], 7'h7F);
    check("t3_digit013", {o_io_hex[27:21], o_io_hex[13:0]}, {7'h0A, 7'h0C, 7'h0D});

    // Misaligned word load.
    do_req(32'h2, 0, 2'b10, 0, 32'h0, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
    check("t4_mis_err", er, 1'b1);
    check("t4_mis_rdata", rd, 32'h0);
`else
    check("t4_mis_err", er, 1'b0);
    check("t4_mis_rdata", rd, 32'h8034_5678);
`endif
    do_req(32'h0, 0, 2'b10, 0, 32'h0, rd, er);
    check("t4_ram_kept", rd, 32'h8034_5678);

    // Switches, read-only, unmapped space, illegal size, LED width.
    i_io_sw = 32'h0000_00FF;
    repeat (3) @(negedge i_clk);
    sw_m = i_io_sw;
    do_req(32'h1001_0000, 0, 2'b10, 0, 32'h0, rd, er);
    check("t5_sw", rd, 32'h0000_00FF);
    do_req(32'h1001_0000, 1, 2'b10, 0, 32'hDEAD_BEEF, rd, er);
    check("t5_sw_store_err", er, 1'b0);
    do_req(32'h1001_0000, 0, 2'b10, 0, 32'h0, rd, er);
    check("t5_sw_kept", rd, 32'h0000_00FF);
    do_req(32'h2000_0000, 0, 2'b10, 0, 32'h0, rd, er);
    check("t5_unmapped", rd, 32'h0);
    do_req(32'h0000_2000, 1, 2'b10, 0, 32'h5555_5555, rd, er);
    do_req(32'h0000_2000, 0, 2'b10, 0, 32'h0, rd, er);
    check("t5_past_ram", rd, 32'h0);
    do_req(32'h1000_4000, 0, 2'b10, 0, 32'h0, rd, er);
    check("t5_hex_grp2_unmapped", rd, 32'h0);
    do_req(32'h0, 1, 2'b11, 0, 32'hFFFF_FFFF, rd, er);
    check("t5_ill_err", er, 1'b1);
    do_req(32'h0, 0, 2'b10, 0, 32'h0, rd, er);
    check("t5_ill_nowrite", rd, 32'h8034_5678);
    do_req(32'h1000_0000, 1, 2'b10, 0, 32'hFFFF_FFFF, rd, er);
    do_req(32'h1000_0000, 0, 2'b10, 0, 32'h0, rd, er);
    check("t5_ledr_width", rd, 32'h0001_FFFF);
    do_req(32'h1000_1000, 1, 2'b10, 0, 32'h1234_56A5, rd, er);

    // Reset during ACCESS of a load: no response, MMIO cleared.
    i_req_valid = 1'b1; i_req_addr = 32'h0; i_req_wren = 0; i_req_size = 2'b10;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    i_reset     = 1'b1;
    pulses = 0;
    repeat (4) begin @(negedge i_clk); if (o_rsp_valid) pulses++; end
    check("t6_no_rsp", pulses, 0);
    check("t6_ready_in_reset", o_req_ready, 1'b0);
    model_reset();
    check_io("t6");
    i_reset = 1'b0;
    @(negedge i_clk);
    check("t6_ready_after", o_req_ready, 1'b1);

    // A store accepted just before reset stays committed.
    i_req_valid = 1'b1; i_req_addr = 32'h40; i_req_wren = 1; i_req_size = 2'b10;
    i_req_wdata = 32'hCAFE_F00D;
    model_req(32'h40, 1, 2'b10, 0, 32'hCAFE_F00D, rd, er);
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    i_reset     = 1'b1;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    do_req(32'h40, 0, 2'b10, 0, 32'h0, rd, er);
    check("t6_store_kept", rd, 32'hCAFE_F00D);

    // Randomized traffic: seed the RAM window, then mix regions and sizes.
    for (int i = 0; i < 64; i++) do_req(32'(4 * i), 1, 2'b10, 0, $urandom, rd, er);
    for (int n = 0; n < 300; n++) begin
      if (n % 50 == 0) begin
        i_io_sw = $urandom;
        repeat (3) @(negedge i_clk);
        sw_m = i_io_sw;
      end
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 32'($urandom_range(0, 255));
        4:          a = 32'h1000_0000 | ($urandom & 32'hFFF);
        5:          a = 32'h1000_1000 | ($urandom & 32'hFFF);
        6:          a = 32'h1000_2000 + 32'($urandom_range(0, 3)) * 32'h1000 + ($urandom & 32'hFFF);
        7:          a = 32'h1000_6000 | ($urandom & 32'hFFF);
        8:          a = 32'h1001_0000 | ($urandom & 32'hFFF);
        default:    a = $urandom | 32'h8000_0000;
      endcase
      do_req(a, 1'($urandom), ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
             1'($urandom), $urandom, rd, er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
